// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// register bit positions, FSM state codes and the byte-select helper.
package uart_pkg;

    // Register byte offsets within the 16-byte window
    localparam logic [31:0] OFF_TXDATA  = 32'h0;
    localparam logic [31:0] OFF_STATUS  = 32'h4;
    localparam logic [31:0] OFF_CTRL    = 32'h8;
    localparam logic [31:0] OFF_BAUDDIV = 32'hC;

    // STATUS bit positions
    localparam int unsigned STATUS_EMPTY = 0;
    localparam int unsigned STATUS_FULL  = 1;
    localparam int unsigned STATUS_BUSY  = 2;
    localparam int unsigned STATUS_OVF   = 3;
    localparam int unsigned STATUS_LVL   = 8;

    // CTRL bit positions
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_NBYTES    = 1;
    localparam int unsigned CTRL_LSB_FIRST = 3;
    localparam int unsigned CTRL_IE        = 4;

    // CTRL register image, MSB first
    typedef struct packed {
        logic       ie;
        logic       lsb_first;
        logic [1:0] nbytes_m1;
        logic       en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{ie: 1'b0, lsb_first: 1'b0, nbytes_m1: 2'd3, en: 1'b1};

    // Serialiser FSM state codes
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Pick the idx-th transmitted byte of a word for the chosen byte order
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx,
                                            input logic lsb_first);
        logic [1:0] pos;
        pos = lsb_first ? idx : 2'd3 - idx;
        return word[8*pos +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-bus connection of the UART transmitter: write strobe, address,
// write data and combinational read data.
interface uart_tx_mmio_if;
    logic        we;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (output we, output address, output dataIn, input dataOut);
    modport slave  (input we, input address, input dataIn, output dataOut);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter. Read data is the head entry,
// available combinationally. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam int unsigned Depth = 2 ** AW;

    logic [W-1:0]  mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == (AW + 1)'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage array; no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
            else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter. Words written to TXDATA are queued and each
// is sent as 1..4 8N1 frames. The line output is registered from the current
// FSM state, so it trails the state by one clock.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 868
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_mmio_if.slave    bus,
    output logic             serial,
    output logic             irq
);
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

    // Register file
    ctrl_t            ctrl_q;
    logic [DIV_W-1:0] baud_q;
    logic             ovf_q;

    // FIFO
    logic [31:0]      fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FIFO_AW:0] fifo_level;

    // Serialiser
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [1:0]       nb_q, nb_d;
    logic             lsb_q, lsb_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             last_tick;

    logic sel_tx, sel_status, sel_ctrl, sel_baud, busy;

    assign sel_tx     = (bus.address == BASE_ADDR + OFF_TXDATA);
    assign sel_status = (bus.address == BASE_ADDR + OFF_STATUS);
    assign sel_ctrl   = (bus.address == BASE_ADDR + OFF_CTRL);
    assign sel_baud   = (bus.address == BASE_ADDR + OFF_BAUDDIV);

    assign busy      = (state_q != StIdle);
    assign fifo_push = bus.we && sel_tx;
    assign fifo_pop  = (state_q == StIdle) && ctrl_q.en && !fifo_empty;
    assign last_tick = (cnt_q == div_q - DivOne);

    assign serial = serial_q;
    assign irq    = ctrl_q.ie && fifo_empty && !busy;

    sync_fifo #(
        .W  (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (bus.dataIn),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // CTRL/BAUDDIV writes and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= CTRL_RESET;
            baud_q <= DIV_W'(DIV_RESET);
            ovf_q  <= 1'b0;
        end else begin
            if (bus.we && sel_ctrl) ctrl_q <= ctrl_t'(bus.dataIn[4:0]);
            if (bus.we && sel_baud) baud_q <= bus.dataIn[DIV_W-1:0];
            // A pop in the same cycle frees a slot, so only a true drop flags overflow
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end else if (bus.we && sel_status && bus.dataIn[STATUS_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Combinational register read-back, zero outside the window
    always_comb begin
        bus.dataOut = '0;
        if (sel_status) begin
            bus.dataOut[STATUS_EMPTY]           = fifo_empty;
            bus.dataOut[STATUS_FULL]            = fifo_full;
            bus.dataOut[STATUS_BUSY]            = busy;
            bus.dataOut[STATUS_OVF]             = ovf_q;
            bus.dataOut[STATUS_LVL +: 8]        = 8'(fifo_level);
        end else if (sel_ctrl) begin
            bus.dataOut[4:0]                    = ctrl_q;
        end else if (sel_baud) begin
            bus.dataOut                         = 32'(baud_q);
        end
    end

    // Serialiser next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        nb_d    = nb_q;
        lsb_d   = lsb_q;
        word_d  = word_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    word_d  = fifo_rdata;
                    byte_d  = 2'd0;
                    nb_d    = ctrl_q.nbytes_m1;
                    lsb_d   = ctrl_q.lsb_first;
                    div_d   = (baud_q == '0) ? DivOne : baud_q;
                    shift_d = byte_sel(fifo_rdata, 2'd0, ctrl_q.lsb_first);
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + DivOne;
                end
            end
            StData: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + DivOne;
                end
            end
            StStop: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (byte_q == nb_q) begin
                        state_d = StIdle;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = byte_sel(word_q, byte_q + 2'd1, lsb_q);
                        state_d = StStart;
                    end
                end else begin
                    cnt_d = cnt_q + DivOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level for the state currently being timed
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_q[0];
            default: serial_d = 1'b1;
        endcase
    end

    // Serialiser state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= DivOne;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            nb_q     <= 2'd0;
            lsb_q    <= 1'b0;
            word_q   <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            nb_q     <= nb_d;
            lsb_q    <= lsb_d;
            word_q   <= word_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

endmodule
